// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - greedy coin-hopper payout sequencer with inventory tracking and ack timeout
module change_dispense_ctrl #(
    parameter int AMT_W        = 8,
    parameter int INV_W        = 6,
    parameter int DENOM3       = 10,
    parameter int DENOM2       = 5,
    parameter int DENOM1       = 2,
    parameter int DENOM0       = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             refill_valid,
    input  logic [1:0]       refill_sel,
    input  logic [INV_W-1:0] refill_count,
    input  logic [3:0]       hopper_ack,
    output logic [3:0]       hopper_pulse,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       fault_code,
    output logic [AMT_W-1:0] remaining,
    output logic [3:0]       inv_empty
);

    localparam int PCW = $clog2(PULSE_CYCLES + 1);
    localparam int TCW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PULSE_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_PULSE, S_WAIT_ACK, S_DONE, S_ERROR
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_sel;
    logic [PCW-1:0]     r_pcnt;
    logic [TCW-1:0]     r_tcnt;
    logic [AMT_W-1:0]   r_remaining;
    logic [1:0]         r_fault;
    logic [INV_W-1:0]   r_inv [4];

    logic               w_ack_ok;
    logic [3:0]         w_fit;
    logic               w_found;
    logic [1:0]         w_pick;
    logic [INV_W:0]     w_sum     [4];
    logic [INV_W-1:0]   w_inv_nxt [4];

    function automatic logic [AMT_W-1:0] denom_of(input logic [1:0] idx);
        case (idx)
            2'd3:    denom_of = AMT_W'(DENOM3);
            2'd2:    denom_of = AMT_W'(DENOM2);
            2'd1:    denom_of = AMT_W'(DENOM1);
            default: denom_of = AMT_W'(DENOM0);
        endcase
    endfunction

    assign w_ack_ok = ((r_state == S_PULSE) || (r_state == S_WAIT_ACK)) && hopper_ack[r_sel];

    // Greedy choice: the highest-index hopper that both fits and is stocked wins.
    always_comb begin
        w_fit   = '0;
        w_found = 1'b0;
        w_pick  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_fit[i] = (r_inv[i] != '0) && (denom_of(2'(i)) <= r_remaining);
            if (w_fit[i]) begin
                w_pick  = 2'(i);
                w_found = 1'b1;
            end
        end
    end

    // Refill and ack decrement combine at INV_W+1 bits; the carry bit flags saturation.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sum[i] = {1'b0, r_inv[i]};
            if (refill_valid && (refill_sel == 2'(i)))
                w_sum[i] = w_sum[i] + {1'b0, refill_count};
            if (w_ack_ok && (r_sel == 2'(i)))
                w_sum[i] = w_sum[i] - 1'b1;
            w_inv_nxt[i] = w_sum[i][INV_W] ? '1 : w_sum[i][INV_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_SELECT;
            S_SELECT: begin
                if (r_remaining == '0)  w_state_nxt = S_DONE;
                else if (w_found)       w_state_nxt = S_PULSE;
                else                    w_state_nxt = S_ERROR;
            end
            S_PULSE: begin
                if (w_ack_ok)               w_state_nxt = S_SELECT;
                else if (r_pcnt == PC_LAST) w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_ack_ok)               w_state_nxt = S_SELECT;
                else if (r_tcnt == TO_LAST) w_state_nxt = S_ERROR;
            end
            S_DONE:     w_state_nxt = S_IDLE;
            S_ERROR:    w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= '0;
            r_pcnt      <= '0;
            r_tcnt      <= '0;
            r_remaining <= '0;
            r_fault     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= change_amount;
                        r_fault     <= 2'd0;
                    end
                end
                S_SELECT: begin
                    if (r_remaining != '0) begin
                        if (w_found) begin
                            r_sel  <= w_pick;
                            r_pcnt <= '0;
                        end else begin
                            r_fault <= 2'd1;
                        end
                    end
                end
                S_PULSE: begin
                    if (w_ack_ok)               r_remaining <= r_remaining - denom_of(r_sel);
                    else if (r_pcnt == PC_LAST) r_tcnt <= '0;
                    else                        r_pcnt <= r_pcnt + 1'b1;
                end
                S_WAIT_ACK: begin
                    if (w_ack_ok)               r_remaining <= r_remaining - denom_of(r_sel);
                    else if (r_tcnt == TO_LAST) r_fault <= 2'd2;
                    else                        r_tcnt <= r_tcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) r_inv[i] <= '0;
            else     r_inv[i] <= w_inv_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) inv_empty[i] = (r_inv[i] == '0);
    end

    assign hopper_pulse = (r_state == S_PULSE) ? (4'b0001 << r_sel) : 4'b0000;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERROR);
    assign fault_code   = r_fault;
    assign remaining    = r_remaining;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - scoreboard bench for change_dispense_ctrl
module tb_change_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] change_amount;
    logic       refill_valid;
    logic [1:0] refill_sel;
    logic [5:0] refill_count;
    logic [3:0] hopper_ack;
    logic [3:0] hopper_pulse;
    logic       busy, done, error;
    logic [1:0] fault_code;
    logic [7:0] remaining;
    logic [3:0] inv_empty;

    change_dispense_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .change_amount(change_amount),
        .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_count(refill_count),
        .hopper_ack(hopper_ack), .hopper_pulse(hopper_pulse), .busy(busy), .done(done),
        .error(error), .fault_code(fault_code), .remaining(remaining), .inv_empty(inv_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [1:0] fault;
        logic [7:0] rem;
        logic [3:0] empty;
        int         gap;
    } res_t;

    typedef struct {
        logic [3:0] onehot;
        int         len;
    } pul_t;

    res_t res_q[$];
    pul_t pul_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic flag(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    task automatic push_res(input logic is_err, input logic [1:0] f, input logic [7:0] r,
                            input logic [3:0] e, input int g);
        res_t t;
        t.is_err = is_err; t.fault = f; t.rem = r; t.empty = e; t.gap = g;
        res_q.push_back(t);
    endtask

    task automatic push_pul(input int idx, input int len, input int n);
        pul_t p;
        p.onehot = 4'b0001 << idx;
        p.len    = len;
        for (int k = 0; k < n; k++) pul_q.push_back(p);
    endtask

    // Monitor: pulses and done/error are checked against the queues as they appear.
    logic [3:0] m_prev = 4'b0;
    int         m_len = 0, m_exp_len = 0, m_gap = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (hopper_pulse != 4'b0 && m_prev == 4'b0) begin
                if (pul_q.size() == 0) begin
                    flag("unexpected_pulse");
                    m_exp_len = 0;
                end else begin
                    pul_t p;
                    p = pul_q.pop_front();
                    chk("pulse_sel", 32'(hopper_pulse), 32'(p.onehot));
                    m_exp_len = p.len;
                end
                m_len = 1;
            end else if (hopper_pulse != 4'b0) begin
                m_len++;
            end else if (m_prev != 4'b0 && m_exp_len > 0) begin
                chk("pulse_len", 32'(m_len), 32'(m_exp_len));
            end
            if (done || error) begin
                if (res_q.size() == 0) begin
                    flag("unexpected_done_error");
                end else begin
                    res_t t;
                    t = res_q.pop_front();
                    chk("error_flag", 32'(error), 32'(t.is_err));
                    chk("done_flag",  32'(done),  32'(!t.is_err));
                    chk("fault_code", 32'(fault_code), 32'(t.fault));
                    chk("remaining",  32'(remaining),  32'(t.rem));
                    chk("inv_empty",  32'(inv_empty),  32'(t.empty));
                    if (t.gap >= 0) chk("idle_gap", 32'(m_gap), 32'(t.gap));
                end
            end
            if (busy && hopper_pulse == 4'b0 && !done && !error) m_gap++;
            else m_gap = 0;
        end
        m_prev = hopper_pulse;
    end

    task automatic refill(input logic [1:0] sel, input logic [5:0] cnt);
        @(negedge clk);
        refill_valid = 1'b1; refill_sel = sel; refill_count = cnt;
        @(negedge clk);
        refill_valid = 1'b0;
    endtask

    task automatic pay(input logic [7:0] amt, input bit ack_en, input bit co_en,
                       input logic [1:0] co_sel, input logic [5:0] co_cnt, input bit extra);
        int cyc;
        bit co_done, ex_done;
        cyc = 0; co_done = 0; ex_done = 0;
        @(negedge clk);
        start = 1'b1; change_amount = amt;
        @(negedge clk);
        start = 1'b0;
        while (busy && cyc < 2000) begin
            hopper_ack = 4'b0; refill_valid = 1'b0; start = 1'b0;
            if (ack_en && hopper_pulse != 4'b0) begin
                hopper_ack = hopper_pulse;
                if (co_en && !co_done) begin
                    refill_valid = 1'b1; refill_sel = co_sel; refill_count = co_cnt;
                    co_done = 1;
                end
            end
            if (extra && !ex_done && hopper_pulse != 4'b0) begin
                start = 1'b1; change_amount = 8'd99; ex_done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        hopper_ack = 4'b0; refill_valid = 1'b0; start = 1'b0;
        if (busy) flag("payout_cycle_budget_expired");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; change_amount = 8'd0; refill_valid = 1'b0;
        refill_sel = 2'd0; refill_count = 6'd0; hopper_ack = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(hopper_pulse), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done_err", 32'({done, error}), 32'h0);
        chk("rst_fault", 32'(fault_code), 32'h0);
        chk("rst_remaining", 32'(remaining), 32'h0);
        chk("rst_inv_empty", 32'(inv_empty), 32'hf);
        rst = 1'b0;

        // 17 = 10 + 5 + 2, with a stray start during payout
        refill(2'd3, 6'd2); refill(2'd2, 6'd1); refill(2'd1, 6'd3);
        push_pul(3, 1, 1); push_pul(2, 1, 1); push_pul(1, 1, 1);
        push_res(1'b0, 2'd0, 8'd0, 4'b0101, 1);
        pay(8'd17, 1, 0, 2'd0, 6'd0, 1);
        chk("t1_remaining_idle", 32'(remaining), 32'h0);

        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;

        // insufficient inventory after one coin
        refill(2'd1, 6'd1);
        push_pul(1, 1, 1);
        push_res(1'b1, 2'd1, 8'd1, 4'b1111, 1);
        pay(8'd3, 1, 0, 2'd0, 6'd0, 0);

        // ack timeout, then confirm h0 still holds 5 coins
        refill(2'd0, 6'd5);
        push_pul(0, 2, 1);
        push_res(1'b1, 2'd2, 8'd1, 4'b1110, 16);
        pay(8'd1, 0, 0, 2'd0, 6'd0, 0);
        push_pul(0, 1, 5);
        push_res(1'b0, 2'd0, 8'd0, 4'b1111, 1);
        pay(8'd5, 1, 0, 2'd0, 6'd0, 0);

        // zero amount latency
        push_res(1'b0, 2'd0, 8'd0, 4'b1111, 1);
        @(negedge clk); start = 1'b1; change_amount = 8'd0;
        @(negedge clk); start = 1'b0;
        chk("zero_sel_busy", 32'(busy), 32'h1);
        chk("zero_sel_done", 32'(done), 32'h0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_done_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("zero_idle", 32'({busy, done}), 32'h0);

        // saturation: 60+10 -> 63, 63-1+1 -> 63, then 10-1+5 -> 14
        refill(2'd2, 6'd60); refill(2'd2, 6'd10);
        push_pul(2, 1, 1);
        push_res(1'b0, 2'd0, 8'd0, 4'b1011, 1);
        pay(8'd5, 1, 1, 2'd2, 6'd1, 0);
        push_pul(2, 1, 50);
        push_res(1'b0, 2'd0, 8'd0, 4'b1011, 1);
        pay(8'd250, 1, 0, 2'd0, 6'd0, 0);
        push_pul(2, 1, 3);
        push_res(1'b0, 2'd0, 8'd0, 4'b1011, 1);
        pay(8'd15, 1, 0, 2'd0, 6'd0, 0);
        push_pul(2, 1, 1);
        push_res(1'b0, 2'd0, 8'd0, 4'b1011, 1);
        pay(8'd5, 1, 1, 2'd2, 6'd5, 0);
        push_pul(2, 1, 14);
        push_res(1'b0, 2'd0, 8'd0, 4'b1111, 1);
        pay(8'd70, 1, 0, 2'd0, 6'd0, 0);
        push_res(1'b1, 2'd1, 8'd5, 4'b1111, 1);
        pay(8'd5, 1, 0, 2'd0, 6'd0, 0);

        // reset while waiting for an ack
        refill(2'd0, 6'd3);
        push_pul(0, 2, 1);
        @(negedge clk); start = 1'b1; change_amount = 8'd1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_waitack", 32'({busy, hopper_pulse}), 32'h10);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_pulse", 32'(hopper_pulse), 32'h0);
        chk("mid_rst_inv_empty", 32'(inv_empty), 32'hf);
        chk("mid_rst_remaining", 32'(remaining), 32'h0);
        chk("mid_rst_fault", 32'(fault_code), 32'h0);
        repeat (25) @(negedge clk);
        chk("results_drained", 32'(res_q.size()), 32'h0);
        chk("pulses_drained", 32'(pul_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
